// File: rtl/khu_pad_pkg.sv
// Shared defaults and constants for the pad input conditioning blocks.
// Also imported by the pad wrapper, so keep the names stable.
package khu_pad_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_W_DEF    = 4;

    // Idle-high lines (UART RX, I2C, active-low requests) come out of reset at 1.
    localparam logic [NUM_CH_DEF-1:0] RESET_VAL_DEF = {NUM_CH_DEF{1'b1}};

    typedef enum logic [1:0] {
        PULSE_NONE,
        PULSE_RISE,
        PULSE_FALL,
        PULSE_GLITCH
    } pulse_e;

endpackage

// File: rtl/pad_input_filter_ch.sv
// One pad channel: N-stage synchronizer, run-time glitch filter, and
// registered level / rise / fall / glitch outputs.
module pad_input_filter_ch
    import khu_pad_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   FILTER_W    = FILTER_W_DEF,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_PAD_IN,
    input  logic                i_FILTER_EN,
    input  logic [FILTER_W-1:0] i_FILTER_LEN,
    output logic                o_LEVEL,
    output logic                o_RISE,
    output logic                o_FALL,
    output logic                o_GLITCH
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    logic [FILTER_W-1:0]    cnt_p1;
    logic [FILTER_W-1:0]    cnt_nxt;
    logic [FILTER_W:0]      cnt_inc;
    logic [FILTER_W:0]      neff;
    logic                   lvl_nxt;
    pulse_e                 pulse_kind;

    // A programmed length of zero means "accept after one stable cycle".
    function automatic logic [FILTER_W:0] eff_len(input logic [FILTER_W-1:0] len);
        return (len == '0) ? (FILTER_W+1)'(1) : {1'b0, len};
    endfunction

    // Stage p0: metastability synchronizer
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync_p0 <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_PAD_IN};
        end
    end

    assign s_p1    = sync_p0[SYNC_STAGES-1];
    assign neff    = eff_len(i_FILTER_LEN);
    assign cnt_inc = {1'b0, cnt_p1} + (FILTER_W+1)'(1);

    // cnt + 1 never exceeds Neff, and >= lets a lowered length take effect at once.
    always_comb begin
        cnt_nxt    = cnt_p1;
        lvl_nxt    = o_LEVEL;
        pulse_kind = PULSE_NONE;
        if (!i_FILTER_EN) begin
            lvl_nxt = s_p1;
            cnt_nxt = '0;
        end else if (s_p1 == o_LEVEL) begin
            if (cnt_p1 != '0) begin
                cnt_nxt    = '0;
                pulse_kind = PULSE_GLITCH;
            end
        end else if (cnt_inc >= neff) begin
            lvl_nxt = s_p1;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_inc[FILTER_W-1:0];
        end
        if (lvl_nxt != o_LEVEL) begin
            pulse_kind = lvl_nxt ? PULSE_RISE : PULSE_FALL;
        end
    end

    // Stage p1: filter state, level and single-cycle pulses
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt_p1   <= '0;
            o_LEVEL  <= RESET_VAL;
            o_RISE   <= 1'b0;
            o_FALL   <= 1'b0;
            o_GLITCH <= 1'b0;
        end else begin
            cnt_p1   <= cnt_nxt;
            o_LEVEL  <= lvl_nxt;
            o_RISE   <= (pulse_kind == PULSE_RISE);
            o_FALL   <= (pulse_kind == PULSE_FALL);
            o_GLITCH <= (pulse_kind == PULSE_GLITCH);
        end
    end

endmodule

// File: rtl/pad_input_filter.sv
// Multi-channel pad input conditioner: NUM_CH independent filtered channels
// plus a registered any-edge summary pulse.
module pad_input_filter
    import khu_pad_pkg::*;
#(
    parameter int                NUM_CH      = NUM_CH_DEF,
    parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int                FILTER_W    = FILTER_W_DEF,
    parameter logic [NUM_CH-1:0] RESET_VAL   = {NUM_CH{1'b1}}
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic [NUM_CH-1:0]   i_PAD_IN,
    input  logic [NUM_CH-1:0]   i_FILTER_EN,
    input  logic [FILTER_W-1:0] i_FILTER_LEN,
    output logic [NUM_CH-1:0]   o_LEVEL,
    output logic [NUM_CH-1:0]   o_RISE,
    output logic [NUM_CH-1:0]   o_FALL,
    output logic [NUM_CH-1:0]   o_GLITCH,
    output logic                o_ANY_EDGE
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pad_input_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W),
            .RESET_VAL   (RESET_VAL[g])
        ) u_ch (
            .i_CLK        (i_CLK),
            .i_RST        (i_RST),
            .i_PAD_IN     (i_PAD_IN[g]),
            .i_FILTER_EN  (i_FILTER_EN[g]),
            .i_FILTER_LEN (i_FILTER_LEN),
            .o_LEVEL      (o_LEVEL[g]),
            .o_RISE       (o_RISE[g]),
            .o_FALL       (o_FALL[g]),
            .o_GLITCH     (o_GLITCH[g])
        );
    end

    // Stage p2: summary pulse, one cycle behind the per-channel pulses
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_ANY_EDGE <= 1'b0;
        end else begin
            o_ANY_EDGE <= |(o_RISE | o_FALL);
        end
    end

endmodule

// File: tb/tb_pad_input_filter.sv
// Self-checking bench for pad_input_filter: vector table plus hand-written
// corner sequences, with pulse events tracked through a scoreboard queue.
module tb_pad_input_filter;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pad;
    logic [3:0] en;
    logic [3:0] len;
    logic [3:0] level, rise, fall, glitch;
    logic       any_edge;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    logic [3:0] exp_lvl;

    // kind: 0 fall, 1 rise, 2 glitch, 3 any-edge
    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [3:0] mask;
        logic [3:0] en;
        logic [3:0] len;
        int         width;
        int         fall_off;
        int         rise_off;
        int         gl_off;
    } vec_t;
    vec_t vecs[11];

    pad_input_filter dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_PAD_IN     (pad),
        .i_FILTER_EN  (en),
        .i_FILTER_LEN (len),
        .o_LEVEL      (level),
        .o_RISE       (rise),
        .o_FALL       (fall),
        .o_GLITCH     (glitch),
        .o_ANY_EDGE   (any_edge)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc = c; e.ch = ch; e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic check_event(input int ch, input int kind);
        bit found = 1'b0;
        total++;
        for (int i = 0; i < sb.size(); i++) begin
            if (!found && sb[i].cyc == cyc && sb[i].ch == ch && sb[i].kind == kind) begin
                sb.delete(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            bad++;
            $display("FAIL pulse ch=%0d kind=%0d at cyc=%0d: seen 1, required 0", ch, kind, cyc);
        end
    endtask

    task automatic flush_check(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            foreach (sb[i])
                $display("FAIL %s missing pulse ch=%0d kind=%0d cyc=%0d: seen 0, required 1",
                         name, sb[i].ch, sb[i].kind, sb[i].cyc);
            sb.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            foreach (sb[i])
                if (sb[i].cyc == cyc && sb[i].kind < 2) exp_lvl[sb[i].ch] = (sb[i].kind == 1);
            total++;
            if (level !== exp_lvl) begin
                bad++;
                $display("FAIL level at cyc=%0d: got %b, required %b", cyc, level, exp_lvl);
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (fall[ch])   check_event(ch, 0);
                if (rise[ch])   check_event(ch, 1);
                if (glitch[ch]) check_event(ch, 2);
            end
            if (any_edge) check_event(0, 3);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        len = v.len;
        en  = v.en;
        repeat (3) @(negedge clk);
        k = cyc;
        pad = pad & ~v.mask;
        for (int ch = 0; ch < 4; ch++) begin
            if (v.mask[ch]) begin
                if (v.fall_off >= 0) begin
                    push_ev(k + v.fall_off, ch, 0);
                    push_ev(k + v.rise_off, ch, 1);
                end
                if (v.gl_off >= 0) push_ev(k + v.gl_off, ch, 2);
            end
        end
        if (v.fall_off >= 0) begin
            push_ev(k + v.fall_off + 1, 0, 3);
            push_ev(k + v.rise_off + 1, 0, 3);
        end
        repeat (v.width) @(negedge clk);
        pad = pad | v.mask;
        repeat (40) @(negedge clk);
        flush_check($sformatf("vec%0d", idx));
    endtask

    initial begin
        int k;
        int m;
        // mask, en, len, width, fall offset, rise offset, glitch offset (-1 = none)
        vecs[0]  = '{4'b0001, 4'b1111, 4'd3,  6,  5, 11, -1};
        vecs[1]  = '{4'b0010, 4'b1111, 4'd4,  2, -1, -1,  5};
        vecs[2]  = '{4'b0100, 4'b1011, 4'd4,  1,  3,  4, -1};
        vecs[3]  = '{4'b1000, 4'b1111, 4'd0,  1,  3,  4, -1};
        vecs[4]  = '{4'b1000, 4'b1111, 4'd1,  1,  3,  4, -1};
        vecs[5]  = '{4'b0001, 4'b1111, 4'd15, 15, 17, 32, -1};
        vecs[6]  = '{4'b0001, 4'b1111, 4'd15, 14, -1, -1, 17};
        vecs[7]  = '{4'b0010, 4'b1111, 4'd2,  1, -1, -1,  4};
        vecs[8]  = '{4'b0100, 4'b1111, 4'd1,  3,  3,  6, -1};
        vecs[9]  = '{4'b0010, 4'b1111, 4'd4,  4,  6, 10, -1};
        vecs[10] = '{4'b1111, 4'b1111, 4'd2,  3,  4,  7, -1};

        rst = 1'b1; pad = 4'b1111; en = 4'b1111; len = 4'd3;
        exp_lvl = 4'b1111;
        repeat (3) @(negedge clk);
        check_val("reset level", level, 4'b1111);
        check_val("reset rise", rise, 4'b0000);
        check_val("reset fall", fall, 4'b0000);
        check_val("reset glitch", glitch, 4'b0000);
        check_val("reset any_edge", {3'b000, any_edge}, 4'b0000);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        flush_check("reset release");

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Length lowered from 15 to 2 while ch0 has counted 5 cycles.
        len = 4'd15; en = 4'b1111;
        repeat (2) @(negedge clk);
        k = cyc;
        pad[0] = 1'b0;
        repeat (7) @(negedge clk);
        len = 4'd2;
        push_ev(k + 8, 0, 0);
        push_ev(k + 9, 0, 3);
        repeat (5) @(negedge clk);
        m = cyc;
        pad[0] = 1'b1;
        push_ev(m + 4, 0, 1);
        push_ev(m + 5, 0, 3);
        repeat (20) @(negedge clk);
        flush_check("len lowered");

        // Filter disabled on ch1 mid-count: level follows, no glitch.
        len = 4'd8;
        repeat (2) @(negedge clk);
        k = cyc;
        pad[1] = 1'b0;
        repeat (4) @(negedge clk);
        en[1] = 1'b0;
        push_ev(k + 5, 1, 0);
        push_ev(k + 6, 0, 3);
        repeat (5) @(negedge clk);
        m = cyc;
        pad[1] = 1'b1;
        push_ev(m + 3, 1, 1);
        push_ev(m + 4, 0, 3);
        repeat (10) @(negedge clk);
        en = 4'b1111;
        repeat (10) @(negedge clk);
        flush_check("enable dropped");

        // Reset while ch3 is pending.
        len = 4'd8;
        repeat (2) @(negedge clk);
        pad[3] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid reset level", level, 4'b1111);
        check_val("mid reset pulses", rise | fall | glitch, 4'b0000);
        @(negedge clk);
        pad[3] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        flush_check("reset mid-count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
